// File: rtl/rm_lane_releaser_pkg.sv
// Shared types for the runtime-monitor lane releaser: lane states and per-lane slot record.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rm_lane_releaser_pkg;

  // Virtual address width of the core (mirrors riscv::VLEN of the surrounding codebase).
  localparam int unsigned VLEN = 64;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    OPEN   = 2'd1,
    CLOSED = 2'd2,
    DRAIN  = 2'd3
  } rm_lane_state_e;

  typedef struct packed {
    rm_lane_state_e   state;
    logic [VLEN-1:0]  pc0;
    logic [VLEN-1:0]  pc1;
  } rm_lane_slot_t;

endpackage

// File: rtl/rm_lane_slot.sv
// One monitor lane: window FSM (FREE/OPEN/CLOSED/DRAIN), slot PCs, optional drain timeout (RM_LANE_TIMEOUT_EN).
// Latency: state moves on the clock after a strobe; release pulse is registered (one cycle later); violation/err are same-cycle.
// Backpressure: none; illegal strobes are dropped and flagged on err_o.
module rm_lane_slot
  import rm_lane_releaser_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            slot0_i,
  input  logic            slot1_i,
  input  logic [VLEN-1:0] alloc_pc_i,
  input  logic            commit_valid_i,
  input  logic [VLEN-1:0] commit_pc_i,
  input  logic            check_i,
  input  logic            check_pass_i,
  output rm_lane_state_e  state_o,
  output logic [VLEN-1:0] pc0_o,
  output logic            lane_reset_o,
  output logic            violation_o,
  output logic            err_o
);

  rm_lane_slot_t lane_q, lane_d;
  logic          rel_q, rel_d;

`ifdef RM_LANE_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] cnt_q, cnt_d;
`endif

  // Next-state, release request, violation and protocol-error decode for this lane.
  always_comb begin
    lane_d      = lane_q;
    rel_d       = 1'b0;
    violation_o = 1'b0;
    err_o       = 1'b0;
`ifdef RM_LANE_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    unique case (lane_q.state)
      FREE: begin
        if (slot0_i) begin
          lane_d.state = OPEN;
          lane_d.pc0   = alloc_pc_i;
        end
      end
      OPEN: begin
        if (flush_i) begin
          lane_d.state = FREE;
          rel_d        = 1'b1;
        end else if (slot1_i) begin
          lane_d.state = CLOSED;
          lane_d.pc1   = alloc_pc_i;
        end
      end
      CLOSED: begin
        // Flush wins over a same-cycle commit match: the window is abandoned.
        if (flush_i) begin
          lane_d.state = FREE;
          rel_d        = 1'b1;
        end else if (commit_valid_i && (commit_pc_i == lane_q.pc1)) begin
          lane_d.state = DRAIN;
`ifdef RM_LANE_TIMEOUT_EN
          cnt_d        = '0;
`endif
        end
      end
      DRAIN: begin
        if (check_i) begin
          lane_d.state = FREE;
          rel_d        = 1'b1;
          violation_o  = !check_pass_i;
        end
`ifdef RM_LANE_TIMEOUT_EN
        else if (cnt_q == TMO_LAST) begin
          lane_d.state = FREE;
          rel_d        = 1'b1;
          violation_o  = 1'b1;
          err_o        = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: ;
    endcase
    // A lane whose release pulse is visible this cycle is already FREE, so reuse
    // by the allocator passes the FREE test below without a special case.
    if ((slot0_i && (lane_q.state != FREE)) ||
        (slot1_i && (lane_q.state != OPEN)) ||
        (check_i && (lane_q.state != DRAIN))) begin
      err_o = 1'b1;
    end
  end

  // Lane state, PCs and registered release pulse; reset drops everything without a pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lane_q <= '{state: FREE, pc0: '0, pc1: '0};
      rel_q  <= 1'b0;
    end else begin
      lane_q <= lane_d;
      rel_q  <= rel_d;
    end
  end

`ifdef RM_LANE_TIMEOUT_EN
  // Drain-time counter, cleared on DRAIN entry.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  assign state_o      = lane_q.state;
  assign pc0_o        = lane_q.pc0;
  assign lane_reset_o = rel_q;

endmodule

// File: rtl/rm_lane_releaser.sv
// Releasing end of the runtime-monitor lane protocol; returns lanes to the allocator. Optional drain timeout: RM_LANE_TIMEOUT_EN.
// Latency: lane_reset_o one cycle after release; violation_o same cycle as verdict; violation_pc_o/proto_err_o one cycle later.
// Backpressure: none; the allocator, commit stage and checker are never stalled, illegal requests are dropped and flagged.
module rm_lane_releaser
  import rm_lane_releaser_pkg::*;
#(
  parameter int unsigned NUM_LANES      = 4,
  parameter int unsigned LW             = $clog2(NUM_LANES),
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 alloc_valid_i,
  input  logic [LW-1:0]        alloc_lane0_i,
  input  logic [LW-1:0]        alloc_lane1_i,
  input  logic                 alloc_two_lane_i,
  input  logic [VLEN-1:0]      alloc_pc_i,
  input  logic                 commit_valid_i,
  input  logic [VLEN-1:0]      commit_pc_i,
  input  logic                 check_valid_i,
  input  logic [LW-1:0]        check_lane_i,
  input  logic                 check_pass_i,
  output logic [NUM_LANES-1:0] lane_reset_o,
  output logic                 violation_o,
  output logic [VLEN-1:0]      violation_pc_o,
  output logic                 proto_err_o,
  output logic                 busy_o
);

  logic                 alloc_acc;
  logic [NUM_LANES-1:0] slot0_stb, slot1_stb, check_stb;
  logic [NUM_LANES-1:0] lane_viol, lane_err;
  rm_lane_state_e       lane_state [NUM_LANES];
  logic [VLEN-1:0]      lane_pc0   [NUM_LANES];
  logic [VLEN-1:0]      vpc_sel, vpc_q;
  logic                 proto_err_q;

  // Allocation is dropped entirely on a flush cycle.
  assign alloc_acc = alloc_valid_i && !flush_i;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign slot0_stb[g] = alloc_acc &&
                          (alloc_two_lane_i ? (alloc_lane1_i == LW'(g)) : (alloc_lane0_i == LW'(g)));
    assign slot1_stb[g] = alloc_acc && alloc_two_lane_i && (alloc_lane0_i == LW'(g));
    assign check_stb[g] = check_valid_i && (check_lane_i == LW'(g));

    rm_lane_slot #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_slot (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .flush_i       (flush_i),
      .slot0_i       (slot0_stb[g]),
      .slot1_i       (slot1_stb[g]),
      .alloc_pc_i    (alloc_pc_i),
      .commit_valid_i(commit_valid_i),
      .commit_pc_i   (commit_pc_i),
      .check_i       (check_stb[g]),
      .check_pass_i  (check_pass_i),
      .state_o       (lane_state[g]),
      .pc0_o         (lane_pc0[g]),
      .lane_reset_o  (lane_reset_o[g]),
      .violation_o   (lane_viol[g]),
      .err_o         (lane_err[g])
    );
  end

  // Violating-lane PC select (lowest lane wins if timeouts coincide) and busy summary.
  always_comb begin
    vpc_sel = '0;
    busy_o  = 1'b0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (lane_viol[i]) vpc_sel = lane_pc0[i];
      if (lane_state[i] != FREE) busy_o = 1'b1;
    end
  end

  // Sticky protocol-error flag and held violation PC.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      proto_err_q <= 1'b0;
      vpc_q       <= '0;
    end else begin
      if (|lane_err)  proto_err_q <= 1'b1;
      if (|lane_viol) vpc_q       <= vpc_sel;
    end
  end

  assign violation_o    = |lane_viol;
  assign violation_pc_o = vpc_q;
  assign proto_err_o    = proto_err_q;

endmodule

// File: tb/tb_rm_lane_releaser.sv
// Self-checking bench for rm_lane_releaser: lane-array reference model compared every cycle, plus literal spot checks.
// Latency: n/a.
// Backpressure: n/a.
module tb_rm_lane_releaser;
  import rm_lane_releaser_pkg::VLEN;

  localparam int NL = 4;
  localparam int S_FREE = 0, S_OPEN = 1, S_CLOSED = 2, S_DRAIN = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            flush, alloc_valid, two_lane, commit_valid, check_valid, check_pass;
  logic [1:0]      lane0, lane1, check_lane;
  logic [VLEN-1:0] alloc_pc, commit_pc;
  logic [NL-1:0]   lane_reset;
  logic            violation, proto_err, busy;
  logic [VLEN-1:0] violation_pc;

  int checks = 0;
  int errors = 0;
  bit run = 1'b0;

  always #5 clk = ~clk;

  rm_lane_releaser #(.NUM_LANES(NL)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .flush_i         (flush),
    .alloc_valid_i   (alloc_valid),
    .alloc_lane0_i   (lane0),
    .alloc_lane1_i   (lane1),
    .alloc_two_lane_i(two_lane),
    .alloc_pc_i      (alloc_pc),
    .commit_valid_i  (commit_valid),
    .commit_pc_i     (commit_pc),
    .check_valid_i   (check_valid),
    .check_lane_i    (check_lane),
    .check_pass_i    (check_pass),
    .lane_reset_o    (lane_reset),
    .violation_o     (violation),
    .violation_pc_o  (violation_pc),
    .proto_err_o     (proto_err),
    .busy_o          (busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: array of lanes, updated per clock ----------------
  int            m_st [NL];
  int            o_st [NL];
  logic [VLEN-1:0] m_pc0 [NL];
  logic [VLEN-1:0] m_pc1 [NL];
  logic [VLEN-1:0] m_vpc;
  logic [NL-1:0] m_rel, n_rel;
  bit            m_err;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NL; i++) begin
        m_st[i] = S_FREE; m_pc0[i] = '0; m_pc1[i] = '0;
      end
      m_rel = '0; m_err = 1'b0; m_vpc = '0;
    end else begin
      n_rel = '0;
      for (int i = 0; i < NL; i++) o_st[i] = m_st[i];
      if (flush) begin
        for (int i = 0; i < NL; i++)
          if (o_st[i] == S_OPEN || o_st[i] == S_CLOSED) begin
            m_st[i] = S_FREE; n_rel[i] = 1'b1;
          end
      end else begin
        for (int i = 0; i < NL; i++)
          if (o_st[i] == S_CLOSED && commit_valid && commit_pc == m_pc1[i]) m_st[i] = S_DRAIN;
        if (alloc_valid) begin
          if (two_lane) begin
            if (o_st[lane0] == S_OPEN) begin m_st[lane0] = S_CLOSED; m_pc1[lane0] = alloc_pc; end
            else m_err = 1'b1;
            if (o_st[lane1] == S_FREE) begin m_st[lane1] = S_OPEN; m_pc0[lane1] = alloc_pc; end
            else m_err = 1'b1;
          end else begin
            if (o_st[lane0] == S_FREE) begin m_st[lane0] = S_OPEN; m_pc0[lane0] = alloc_pc; end
            else m_err = 1'b1;
          end
        end
      end
      if (check_valid) begin
        if (o_st[check_lane] == S_DRAIN) begin
          m_st[check_lane] = S_FREE; n_rel[check_lane] = 1'b1;
          if (!check_pass) m_vpc = m_pc0[check_lane];
        end else m_err = 1'b1;
      end
      m_rel = n_rel;
    end
  end

  // ---------------- per-cycle compare against the model ----------------
  bit e_busy, e_viol;
  always @(negedge clk) begin
    if (run && !rst) begin
      e_busy = 1'b0;
      for (int i = 0; i < NL; i++) if (m_st[i] != S_FREE) e_busy = 1'b1;
      e_viol = check_valid && !check_pass && (m_st[check_lane] == S_DRAIN);
      chk("model_lane_reset", 64'(lane_reset), 64'(m_rel));
      chk("model_busy", 64'(busy), 64'(e_busy));
      chk("model_violation", 64'(violation), 64'(e_viol));
      chk("model_violation_pc", 64'(violation_pc), 64'(m_vpc));
      chk("model_proto_err", 64'(proto_err), 64'(m_err));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic idle();
    flush = 0; alloc_valid = 0; two_lane = 0; lane0 = 0; lane1 = 0; alloc_pc = '0;
    commit_valid = 0; commit_pc = '0; check_valid = 0; check_lane = 0; check_pass = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic alloc1(input logic [1:0] l, input logic [VLEN-1:0] pc);
    alloc_valid = 1; two_lane = 0; lane0 = l; alloc_pc = pc; tick(); idle();
  endtask

  task automatic alloc2(input logic [1:0] l0, input logic [1:0] l1, input logic [VLEN-1:0] pc);
    alloc_valid = 1; two_lane = 1; lane0 = l0; lane1 = l1; alloc_pc = pc; tick(); idle();
  endtask

  task automatic commit(input logic [VLEN-1:0] pc);
    commit_valid = 1; commit_pc = pc; tick(); idle();
  endtask

  task automatic check(input logic [1:0] l, input logic pass);
    check_valid = 1; check_lane = l; check_pass = pass; tick(); idle();
  endtask

  initial begin
    idle();
    rst = 1;
    tick(); tick();
    chk("reset_lane_reset", 64'(lane_reset), 64'h0);
    chk("reset_busy", 64'(busy), 64'h0);
    chk("reset_violation", 64'(violation), 64'h0);
    chk("reset_violation_pc", 64'(violation_pc), 64'h0);
    chk("reset_proto_err", 64'(proto_err), 64'h0);
    rst = 0; run = 1;
    tick();

    // Single slot0 allocation
    alloc1(2'd2, 64'h100);
    chk("single_busy", 64'(busy), 64'h1);
    chk("single_no_pulse", 64'(lane_reset), 64'h0);

    // Close and release lane2 with a pass verdict; lane0 opens
    alloc2(2'd2, 2'd0, 64'h104);
    commit(64'h104);
    check(2'd2, 1'b1);
    chk("release_pulse", 64'(lane_reset), 64'b0100);
    tick();
    chk("release_pulse_width", 64'(lane_reset), 64'h0);
    chk("release_lane0_open", 64'(busy), 64'h1);

    // Violation on lane2
    alloc1(2'd2, 64'h200);
    alloc2(2'd2, 2'd1, 64'h204);
    commit(64'h204);
    check_valid = 1; check_lane = 2'd2; check_pass = 0; #1;
    chk("viol_pulse", 64'(violation), 64'h1);
    tick(); idle();
    chk("viol_pc", 64'(violation_pc), 64'h200);
    chk("viol_release", 64'(lane_reset), 64'b0100);

    // Build: lane0 DRAIN, lane1 OPEN, lane2 OPEN, lane3 DRAIN
    alloc2(2'd0, 2'd3, 64'h300);
    commit(64'h300);
    alloc2(2'd3, 2'd2, 64'h308);
    commit(64'h308);

    // Flush with a concurrent (would-be illegal) allocation
    flush = 1; alloc_valid = 1; two_lane = 0; lane0 = 2'd1; alloc_pc = 64'h500;
    tick(); idle();
    chk("flush_pulse", 64'(lane_reset), 64'b0110);
    chk("flush_alloc_ignored", 64'(proto_err), 64'h0);
    chk("flush_drain_kept", 64'(busy), 64'h1);
    check(2'd0, 1'b1);
    chk("drain0_release", 64'(lane_reset), 64'b0001);
    check(2'd3, 1'b1);
    chk("drain3_release", 64'(lane_reset), 64'b1000);

    // Reuse lane3 during its release pulse cycle
    alloc1(2'd3, 64'h400);
    chk("reuse_no_err", 64'(proto_err), 64'h0);
    chk("reuse_busy", 64'(busy), 64'h1);

    // Commit match and verdict in the same cycle on a CLOSED lane
    alloc2(2'd3, 2'd0, 64'h408);
    commit_valid = 1; commit_pc = 64'h408;
    check_valid = 1; check_lane = 2'd3; check_pass = 1; #1;
    chk("cc_no_viol", 64'(violation), 64'h0);
    tick(); idle();
    chk("cc_proto_err", 64'(proto_err), 64'h1);
    chk("cc_no_pulse", 64'(lane_reset), 64'h0);
    repeat (5) tick();
    chk("drain_waits", 64'(busy), 64'h1);

    // Asynchronous reset mid-operation
    rst = 1; #1;
    chk("arst_busy", 64'(busy), 64'h0);
    chk("arst_proto_err", 64'(proto_err), 64'h0);
    chk("arst_vpc", 64'(violation_pc), 64'h0);
    tick();
    chk("arst_no_pulse", 64'(lane_reset), 64'h0);
    rst = 0;
    tick();

    // Verdict for a FREE lane
    check(2'd1, 1'b1);
    chk("free_check_err", 64'(proto_err), 64'h1);
    chk("free_check_no_pulse", 64'(lane_reset), 64'h0);

    repeat (3) tick();
    run = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
